elevator_request_latch: RTL and testbench
=========================================

// Module: elevator_request_latch
// PURPOSE
//  Upstream stage of the 4-floor elevator controller. Synchronises and debounces raw
//  floor-button inputs, latches them as pending requests and drives the controller's
//  one-hot request[3:0]. Clears a request when the car stops at its floor, then holds
//  the door open for a fixed dwell. Requests are masked during the dwell so the car
//  cannot leave.
// PARAMETERS
//  NUM_FLOORS       4    floors served; fixed at 4, matches controller request width
//  DEBOUNCE_CYCLES  16   consecutive stable synced samples before a press is accepted
//  DOOR_CYCLES      64   door-open dwell length in clk cycles (>=2)
// PORTS
//  clk            in   1  system clock, all logic on posedge
//  reset_n        in   1  asynchronous, active-low reset
//  button         in   4  raw asynchronous floor buttons, active-high, bit i = floor i
//  current_floor  in   2  floor indicator from controller
//  moving         in   1  controller moving flag
//  request        out  4  pending requests to controller, masked to 0 while door_open
//  door_open      out  1  high for the whole dwell
//  served         out  1  1-cycle pulse when a request is cleared
//  served_floor   out  2  floor cleared; valid when served=1, holds last value otherwise
// BEHAVIOUR
//  - Reset (async assert, sync release): pending=0, request=0, door_open=0, served=0,
//    served_floor=0, FSM=IDLE. Sync flops, debounce counters and dwell counter cleared.
//    Reset mid-dwell discards all pending requests and closes the door immediately.
//  - Input path per bit: 2-flop synchroniser, then debouncer. The debounced level
//    changes only after the synced level differs from it for DEBOUNCE_CYCLES
//    consecutive cycles. A bounce restarts the count.
//  - Latch: a rising edge of debounced[i] sets pending[i] on the next edge. If pending[i]
//    is already set, the edge has no effect. Falling edges are ignored.
//  - request = door_open ? 4'b0 : pending. Registered output, no combinational path
//    from button.
//  - FSM (2 states):
//    IDLE: if moving==0 && pending[current_floor], then on the next edge:
//      clear that pending bit; served=1; served_floor=current_floor;
//      door_open=1; dwell counter=DOOR_CYCLES-1; go to DOOR.
//    DOOR: counter decrements each cycle. Leave to IDLE when it wraps at 0 (edge after
//      counter==0); door_open falls on that same edge. door_open is high for exactly
//      DOOR_CYCLES cycles.
//  - During DOOR, presses for other floors still set pending. They are exposed on
//    request once door_open falls.
//  - A press for the served floor during DOOR is ignored (not latched); see REOPEN option.
//  - Simultaneous set and clear of the same bit in one cycle: clear wins.
//  - moving==1 never clears a request, even if current_floor matches.
//  - Debounce counter width = $clog2(DEBOUNCE_CYCLES+1). Dwell counter width =
//    $clog2(DOOR_CYCLES). Both saturate/reload; neither wraps.
// CONFIGURATION
//  ELEV_DOOR_REOPEN_EN defined:
//    in DOOR, a debounced rising edge for served_floor reloads the dwell counter to
//    DOOR_CYCLES-1. door_open stays high, served does not re-pulse, pending is unchanged.
//  Not defined:
//    such presses are dropped as stated above. There is no reload logic.
// STRUCTURE
//  Shared package elev_pkg:
//    NUM_FLOORS and FLOOR_0..FLOOR_3 2-bit constants (shared with the controller);
//    floor_t typedef (logic [1:0]); req_state_t enum {IDLE, DOOR}.
//  Sub-module button_debounce (sync + debounce, one bit, parameter DEBOUNCE_CYCLES):
//    instantiated 4x via generate. Latch, FSM and dwell counter live in the top level.
// TESTING (sim with DEBOUNCE_CYCLES=4, DOOR_CYCLES=8)
//  1 Reset: reset_n=0 with button=4'hF -> request=0, door_open=0, served=0.
//    Release with buttons low -> outputs stay 0.
//  2 Latch: moving=1, floor 0, button[2] held 10 cycles -> request=4'b0100 within
//    2+4+1 cycles of the press. A 2-cycle glitch on button[1] -> no change.
//  3 Serve: pending 4'b0100, current_floor=2, moving=0 ->
//    1 cycle later served=1, served_floor=2, door_open=1, request=0.
//    door_open high 8 cycles, then request=0 (bit cleared).
//  4 Queue during dwell: press floor 3 during DOOR -> request=0 until door_open falls,
//    then request=4'b1000. Press floor 2 during DOOR (no REOPEN) -> never latched.
//  5 Reset mid-dwell: assert reset_n=0 in cycle 3 of DOOR with pending 4'b1001 ->
//    door_open, request, pending all 0 immediately.
//  6 REOPEN build: press served floor in dwell cycle 5 -> door_open stays high
//    8 more cycles; served pulses once in total.

Source files
------------

// File: rtl/elev_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elev_pkg
//  Description : Shared types and constants for the 4-floor elevator
//                controller and its request latch front end.
//                NUM_FLOORS     - floors served (fixed at 4)
//                FLOOR_0..3     - 2-bit floor codes
//                floor_t        - floor index type
//                req_state_t    - request latch FSM states
//                floor_onehot() - floor code to one-hot request mask
//  Revision    : 1.0 - initial release
// ============================================================================
package elev_pkg;

  localparam int NUM_FLOORS = 4;

  typedef logic [1:0] floor_t;

  localparam floor_t FLOOR_0 = 2'd0;
  localparam floor_t FLOOR_1 = 2'd1;
  localparam floor_t FLOOR_2 = 2'd2;
  localparam floor_t FLOOR_3 = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    DOOR = 1'b1
  } req_state_t;

  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input floor_t f);
    floor_onehot    = '0;
    floor_onehot[f] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Single-bit synchroniser plus debouncer for a raw floor
//                button. The debounced level follows the synchronised level
//                only after it has differed for DEBOUNCE_CYCLES consecutive
//                cycles; any return to the current level restarts the count.
//  Ports       : clk       - system clock
//                reset_n   - asynchronous active-low reset
//                button    - raw asynchronous button input
//                debounced - filtered, clock-domain level
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic debounced
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      cnt       <= '0;
      debounced <= 1'b0;
    end else begin
      sync_1 <= button;
      sync_2 <= sync_1;
      if (sync_2 != debounced) begin
        // The edge that sees the final differing sample commits the change,
        // so the counter never climbs past CNT_LAST.
        if (cnt == CNT_LAST) begin
          debounced <= sync_2;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/elevator_request_latch.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_request_latch
//  Description : Debounces the floor buttons, latches pending requests and
//                serves them when the car is stopped at a requested floor,
//                then holds the door open for DOOR_CYCLES cycles. Requests
//                are hidden from the controller while the door is open.
//  Ports       : clk           - system clock
//                reset_n       - asynchronous active-low reset
//                button[3:0]   - raw floor buttons, bit i = floor i
//                current_floor - floor indicator from controller
//                moving        - controller moving flag
//                request[3:0]  - pending requests, zero while door is open
//                door_open     - high for the whole dwell
//                served        - one-cycle pulse when a request is cleared
//                served_floor  - floor last cleared
//  Build macro : ELEV_DOOR_REOPEN_EN - a fresh press of the served floor
//                during the dwell restarts the dwell instead of being dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_request_latch
  import elev_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DOOR_CYCLES     = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] button,
  input  floor_t                current_floor,
  input  logic                  moving,
  output logic [NUM_FLOORS-1:0] request,
  output logic                  door_open,
  output logic                  served,
  output floor_t                served_floor
);

  localparam int DWELL_W = $clog2(DOOR_CYCLES);
  localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(DOOR_CYCLES - 1);

  logic [NUM_FLOORS-1:0] debounced;
  logic [NUM_FLOORS-1:0] debounced_q;
  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] pending;
  logic [NUM_FLOORS-1:0] pending_nx;
  logic [NUM_FLOORS-1:0] request_nx;
  logic [NUM_FLOORS-1:0] set_mask;
  logic [NUM_FLOORS-1:0] clear_mask;
  req_state_t            state;
  req_state_t            state_nx;
  logic [DWELL_W-1:0]    dwell;
  logic [DWELL_W-1:0]    dwell_nx;
  logic                  door_open_nx;
  logic                  served_nx;
  floor_t                served_floor_nx;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_debounce
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .button   (button[i]),
      .debounced(debounced[i])
    );
  end

  assign rise = debounced & ~debounced_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      dwell        <= '0;
      debounced_q  <= '0;
      pending      <= '0;
      request      <= '0;
      door_open    <= 1'b0;
      served       <= 1'b0;
      served_floor <= FLOOR_0;
    end else begin
      state        <= state_nx;
      dwell        <= dwell_nx;
      debounced_q  <= debounced;
      pending      <= pending_nx;
      request      <= request_nx;
      door_open    <= door_open_nx;
      served       <= served_nx;
      served_floor <= served_floor_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    dwell_nx        = dwell;
    door_open_nx    = door_open;
    served_nx       = 1'b0;
    served_floor_nx = served_floor;
    set_mask        = rise;
    clear_mask      = '0;

    case (state)
      IDLE: begin
        if (!moving && pending[current_floor]) begin
          clear_mask      = floor_onehot(current_floor);
          served_nx       = 1'b1;
          served_floor_nx = current_floor;
          door_open_nx    = 1'b1;
          dwell_nx        = DWELL_RELOAD;
          state_nx        = DOOR;
        end
      end
      DOOR: begin
        // A press for the floor being served never becomes a new request.
        set_mask = rise & ~floor_onehot(served_floor);
`ifdef ELEV_DOOR_REOPEN_EN
        if (rise[served_floor]) begin
          dwell_nx = DWELL_RELOAD;
        end else if (dwell == '0) begin
          state_nx     = IDLE;
          door_open_nx = 1'b0;
        end else begin
          dwell_nx = dwell - 1'b1;
        end
`else
        if (dwell == '0) begin
          state_nx     = IDLE;
          door_open_nx = 1'b0;
        end else begin
          dwell_nx = dwell - 1'b1;
        end
`endif
      end
      default: begin
        state_nx     = IDLE;
        door_open_nx = 1'b0;
      end
    endcase

    // Clear is applied after set so a same-cycle clear wins.
    pending_nx = (pending | set_mask) & ~clear_mask;
    request_nx = door_open_nx ? '0 : pending_nx;
  end

endmodule
`default_nettype wire

// File: tb/tb_elevator_request_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elevator_request_latch
//  Description : Self-checking bench for elevator_request_latch with
//                DEBOUNCE_CYCLES=4 and DOOR_CYCLES=8. A behavioural model
//                tracks button history windows, pending requests and the
//                remaining door time; every cycle the DUT outputs are
//                compared against it, alongside directed scenario checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_request_latch;

  localparam int DEB  = 4;
  localparam int DOOR = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] button = 4'h0;
  logic [1:0] current_floor = 2'd0;
  logic       moving = 1'b1;
  logic [3:0] request;
  logic       door_open;
  logic       served;
  logic [1:0] served_floor;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elevator_request_latch #(
    .DEBOUNCE_CYCLES(DEB),
    .DOOR_CYCLES    (DOOR)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .button       (button),
    .current_floor(current_floor),
    .moving       (moving),
    .request      (request),
    .door_open    (door_open),
    .served       (served),
    .served_floor (served_floor)
  );

  // ---------------- behavioural reference model ----------------
  logic [3:0] raw_q0, raw_q1;     // raw samples taken one and two edges ago
  logic [3:0] win [DEB];          // last DEB synchronised samples seen
  logic [3:0] m_db;
  logic [3:0] m_rise_q;
  logic [3:0] m_pend;
  bit         m_door;
  int         m_left;             // door-open cycles still to come
  logic       m_served;
  logic [1:0] m_sf;

  function automatic void m_reset();
    raw_q0 = '0; raw_q1 = '0;
    for (int j = 0; j < DEB; j++) win[j] = '0;
    m_db = '0; m_rise_q = '0; m_pend = '0;
    m_door = 0; m_left = 0; m_served = 1'b0; m_sf = 2'd0;
  endfunction

  function automatic void m_step();
    logic [3:0] seen;
    logic [3:0] rise_now;
    logic [3:0] new_rise;
    bit         differ;
    bit         serve;
    seen   = raw_q1;
    raw_q1 = raw_q0;
    raw_q0 = button;
    for (int j = DEB - 1; j > 0; j--) win[j] = win[j-1];
    win[0] = seen;
    new_rise = '0;
    for (int i = 0; i < 4; i++) begin
      differ = 1;
      for (int j = 0; j < DEB; j++) if (win[j][i] == m_db[i]) differ = 0;
      if (differ) begin
        m_db[i] = ~m_db[i];
        if (m_db[i]) new_rise[i] = 1'b1;
      end
    end
    rise_now = m_rise_q;
    m_rise_q = new_rise;
    m_served = 1'b0;
    if (!m_door) begin
      serve  = !moving && m_pend[current_floor];
      m_pend = m_pend | rise_now;
      if (serve) begin
        m_pend[current_floor] = 1'b0;
        m_door   = 1;
        m_left   = DOOR;
        m_served = 1'b1;
        m_sf     = current_floor;
      end
    end else begin
      m_left = m_left - 1;
`ifdef ELEV_DOOR_REOPEN_EN
      if (rise_now[m_sf]) m_left = DOOR;
`endif
      rise_now[m_sf] = 1'b0;
      m_pend = m_pend | rise_now;
      if (m_left == 0) m_door = 0;
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_reset();
    else          m_step();
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      check("model_request", {4'h0, request}, {4'h0, (m_door ? 4'h0 : m_pend)});
      check("model_door_open", {7'h0, door_open}, {7'h0, m_door});
      check("model_served", {7'h0, served}, {7'h0, m_served});
      check("model_served_floor", {6'h0, served_floor}, {6'h0, m_sf});
    end
  endtask

  int door_cnt;
  int srv_cnt;

  initial begin
    // Reset held with all buttons pressed
    reset_n = 1'b0; button = 4'hF; moving = 1'b1; current_floor = 2'd0;
    tick(3);
    check("rst_request", {4'h0, request}, 8'h00);
    check("rst_door_open", {7'h0, door_open}, 8'h00);
    check("rst_served", {7'h0, served}, 8'h00);
    button = 4'h0; reset_n = 1'b1;
    tick(4);
    check("rst_release_request", {4'h0, request}, 8'h00);

    // Latch floor 2 while moving; then a short glitch on floor 1
    button = 4'b0100;
    tick(6);
    check("latch_early", {4'h0, request}, 8'h00);
    tick(1);
    check("latch", {4'h0, request}, 8'h04);
    tick(3);
    button = 4'b0000;
    button = 4'b0010;
    tick(2);
    button = 4'b0000;
    tick(10);
    check("glitch", {4'h0, request}, 8'h04);

    // Serve floor 2, queue floor 3 and re-press floor 2 during the dwell
    current_floor = 2'd2; moving = 1'b0;
    tick(1);
    check("serve_pulse", {7'h0, served}, 8'h01);
    check("serve_floor", {6'h0, served_floor}, 8'h02);
    check("serve_door", {7'h0, door_open}, 8'h01);
    check("serve_request", {4'h0, request}, 8'h00);
    button = 4'b1100;
    tick(7);
    check("dwell_last_door", {7'h0, door_open}, 8'h01);
    check("dwell_masked", {4'h0, request}, 8'h00);
    tick(1);
    check("dwell_closed", {7'h0, door_open}, 8'h00);
    check("queued_exposed", {4'h0, request}, 8'h08);
    button = 4'b0000;
    tick(10);
    check("served_floor_dropped", {4'h0, request}, 8'h08);

    // Reset in the third dwell cycle with 4'b1001 pending
    moving = 1'b1;
    button = 4'b0011;
    tick(10);
    button = 4'b0000;
    tick(8);
    check("pending_1011", {4'h0, request}, 8'h0B);
    current_floor = 2'd1; moving = 1'b0;
    tick(1);
    check("serve1_pulse", {7'h0, served}, 8'h01);
    tick(2);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_door", {7'h0, door_open}, 8'h00);
    check("midreset_request", {4'h0, request}, 8'h00);
    tick(2);
    reset_n = 1'b1;
    tick(10);
    check("midreset_pending_gone", {4'h0, request}, 8'h00);

    // Press the served floor partway through the dwell
    moving = 1'b1; current_floor = 2'd0;
    button = 4'b0001;
    tick(10);
    button = 4'b0000;
    tick(8);
    check("pending_floor0", {4'h0, request}, 8'h01);
    button = 4'b0001;
    tick(2);
    moving = 1'b0;
    door_cnt = 0; srv_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      door_cnt += int'(door_open);
      srv_cnt  += int'(served);
    end
`ifdef ELEV_DOOR_REOPEN_EN
    check("door_len", door_cnt[7:0], 8'd12);
`else
    check("door_len", door_cnt[7:0], 8'd8);
`endif
    check("served_once", srv_cnt[7:0], 8'd1);
    check("repress_not_pending", {4'h0, request}, 8'h00);
    button = 4'b0000;
    tick(8);

    // Randomised traffic against the model, with one reset in the middle
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 11) == 0) button[i] = ~button[i];
      if ($urandom_range(0, 7) == 0) moving = ~moving;
      if (moving && $urandom_range(0, 3) == 0) current_floor = 2'($urandom_range(0, 3));
      if (c == 400) reset_n = 1'b0;
      if (c == 403) reset_n = 1'b1;
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
